alu_cmd_ctrl: RTL and testbench
===============================

Name: alu_cmd_ctrl

Overview:
- Command sequencer that sits directly upstream of the ALU.
- Parses command frames arriving as bytes from the UART receiver and drives the ALU operands, function and enable.
- Waits for the ALU result and returns it to the UART transmitter as two bytes, low byte first.
- Holds the last operands so a short frame can re-run a new function on them.

Parameters:
- OPERAND_WIDTH, 8, ALU operand width; must be 8 because one operand is one UART byte.
- RESULT_WIDTH, 16, ALU result width; returned as two bytes.
- TIMEOUT, 15, maximum cycles spent waiting for ALU_OUT_Valid.
- ERR_CODE, 8'hEE, byte sent to the transmitter on timeout.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- RX_P_DATA  in  8  received byte.
- RX_D_VLD  in  1  single-cycle strobe; RX_P_DATA is valid in that cycle.
- ALU_A  out  OPERAND_WIDTH  operand A to the ALU.
- ALU_B  out  OPERAND_WIDTH  operand B to the ALU.
- ALU_FUN  out  4  ALU function code.
- ALU_EN  out  1  ALU enable, one-cycle pulse.
- ALU_OUT  in  RESULT_WIDTH  ALU result.
- ALU_OUT_Valid  in  1  ALU result-valid flag.
- TX_P_DATA  out  8  byte to the transmitter.
- TX_D_VLD  out  1  transmit request.
- TX_BUSY  in  1  transmitter busy.
- CTRL_BUSY  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high. All state is updated on the rising edge of CLK only.
- Reset values: all outputs 0. FSM to IDLE. Operand registers 0. Timeout counter 0.
- Reset mid-operation: any partial frame or pending transmission is discarded and TX_D_VLD drops on the next edge.
- Frames:
  - 0xCC, A, B, FUN: load new operands, then run.
  - 0xDD, FUN: run with the stored ALU_A and ALU_B.
  - Only FUN[3:0] is used; bits [7:4] are ignored.
- FSM states: IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, ALU_WAIT, CAPTURE, SEND_LO, SEND_HI, SEND_ERR.
- IDLE:
  - On RX_D_VLD with 0xCC go to GET_A; with 0xDD go to GET_FUN.
  - Any other byte is ignored and the FSM stays in IDLE.
- GET_A, GET_B, GET_FUN: each RX_D_VLD loads the byte into ALU_A, ALU_B or ALU_FUN respectively and advances. No resynchronisation: 0xCC or 0xDD received in these states is plain data.
- ALU_RUN:
  - Entered on the edge after the FUN byte strobe.
  - ALU_EN = 1 for exactly this one cycle, then go to ALU_WAIT.
- ALU_WAIT:
  - Counter increments every cycle.
  - If ALU_OUT_Valid = 1, go to CAPTURE.
  - Otherwise, if the counter reaches TIMEOUT, go to SEND_ERR.
  - If Valid arrives in the same cycle the counter reaches TIMEOUT, Valid wins.
- CAPTURE:
  - ALU_OUT is registered, so it lags Valid by one cycle.
  - Sample ALU_OUT into the result register in this cycle, one cycle after Valid was seen, then go to SEND_LO.
- Operand and function hold: ALU_A, ALU_B and ALU_FUN stay stable from GET_FUN until the FSM returns to IDLE. The ALU output mux depends on ALU_FUN.
- Transmit handshake (SEND_LO, SEND_HI, SEND_ERR):
  - Wait until TX_BUSY = 0, then drive TX_P_DATA and assert TX_D_VLD.
  - Hold both stable until TX_BUSY is sampled high (byte accepted), then deassert TX_D_VLD on the next edge.
  - SEND_HI waits for TX_BUSY = 0 again before presenting its byte.
- Transmit order: SEND_LO sends result[7:0], then SEND_HI sends result[15:8], then IDLE. SEND_ERR sends ERR_CODE, then IDLE.
- RX bytes arriving in ALU_RUN through SEND_* are dropped.
- Latency: FUN strobe at edge k, then ALU_EN high during cycle k+1.

Optional Feature:
- Macro: ALU_CTRL_TIMEOUT_EN.
- Defined: the timeout counter, TIMEOUT, ERR_CODE and the SEND_ERR state are present, as described above.
- Undefined: the counter and SEND_ERR are removed. ALU_WAIT waits indefinitely for ALU_OUT_Valid; only RST exits.

Test Plan:
- Add with new operands: RX CC,05,03,00 → ALU_A=05, ALU_B=03, ALU_FUN=0, one ALU_EN pulse. Bench ALU returns 0x0008 → TX sends 08 then 00; CTRL_BUSY falls after the second byte.
- Reuse stored operands: following the add frame, RX DD,02 → ALU_EN with A=05, B=03, FUN=2. Result 0x000F → TX sends 0F, 00.
- Unknown opcode: RX 55 → stays IDLE, CTRL_BUSY=0. A following CC,FF,01,00 with result 0x0100 → TX sends 00, 01.
- Timeout: Valid never asserted → TX sends EE after TIMEOUT(15) wait cycles, then IDLE. With the macro undefined, CTRL_BUSY stays 1 for 100 cycles with no TX_D_VLD.
- Reset mid-frame: RX CC,07 then RST for 1 cycle → all outputs 0 and ALU_A=00. A following DD,00 runs with A=00, B=00.
- Transmitter back-pressure: TX_BUSY held high 20 cycles before the low byte → TX_D_VLD stays low until TX_BUSY=0. TX_P_DATA is stable while TX_D_VLD=1, and the high byte is not presented until TX_BUSY returns to 0.

Source files
------------

// File: rtl/alu_cmd_ctrl_if.sv
// Signal bundle between alu_cmd_ctrl and its neighbours: UART RX, UART TX and the ALU.
// The master modport is the command controller; slave is the surrounding logic.
interface alu_cmd_ctrl_if #(
  parameter int OPERAND_WIDTH = 8,
  parameter int RESULT_WIDTH  = 16
);
  logic [7:0]               RX_P_DATA;
  logic                     RX_D_VLD;
  logic [OPERAND_WIDTH-1:0] ALU_A;
  logic [OPERAND_WIDTH-1:0] ALU_B;
  logic [3:0]               ALU_FUN;
  logic                     ALU_EN;
  logic [RESULT_WIDTH-1:0]  ALU_OUT;
  logic                     ALU_OUT_Valid;
  logic [7:0]               TX_P_DATA;
  logic                     TX_D_VLD;
  logic                     TX_BUSY;
  logic                     CTRL_BUSY;

  modport master (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_Valid, TX_BUSY,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CTRL_BUSY
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_Valid, TX_BUSY,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CTRL_BUSY
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// UART-to-ALU command sequencer: parses CC/DD frames, pulses the ALU and returns the result.
// Define ALU_CTRL_TIMEOUT_EN to add the ALU_WAIT timeout counter and the SEND_ERR error byte.
module alu_cmd_ctrl #(
  parameter int OPERAND_WIDTH = 8,
  parameter int RESULT_WIDTH  = 16
`ifdef ALU_CTRL_TIMEOUT_EN
  ,
  parameter int         TIMEOUT  = 15,
  parameter logic [7:0] ERR_CODE = 8'hEE
`endif
) (
  input  logic           CLK,
  input  logic           RST,
  alu_cmd_ctrl_if.master bus
);

  localparam logic [7:0] CMD_LOAD  = 8'hCC;
  localparam logic [7:0] CMD_REUSE = 8'hDD;

  typedef enum logic [3:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_FUN,
    ALU_RUN,
    ALU_WAIT,
    CAPTURE,
    SEND_LO,
    SEND_HI
`ifdef ALU_CTRL_TIMEOUT_EN
    ,
    SEND_ERR
`endif
  } state_e;

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [OPERAND_WIDTH-1:0] r_alu_a;
  logic [OPERAND_WIDTH-1:0] w_alu_a_nxt;
  logic [OPERAND_WIDTH-1:0] r_alu_b;
  logic [OPERAND_WIDTH-1:0] w_alu_b_nxt;
  logic [3:0]               r_alu_fun;
  logic [3:0]               w_alu_fun_nxt;
  logic [RESULT_WIDTH-1:0]  r_result;
  logic [RESULT_WIDTH-1:0]  w_result_nxt;
  logic [7:0]               r_tx_data;
  logic [7:0]               w_tx_data_nxt;
  logic                     r_tx_vld;
  logic                     w_tx_vld_nxt;

  // Transmit-side selection shared by every SEND_* state.
  logic                     w_send;
  logic [7:0]               w_tx_byte;
  state_e                   w_send_done;

`ifdef ALU_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
`endif

  // NOTE: synchronous reset lives inside the clocked block; state uses <= only so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
      r_result  <= '0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_alu_a   <= w_alu_a_nxt;
      r_alu_b   <= w_alu_b_nxt;
      r_alu_fun <= w_alu_fun_nxt;
      r_result  <= w_result_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_vld  <= w_tx_vld_nxt;
`ifdef ALU_CTRL_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
`endif
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path leaves one
  // unassigned and no latch can be inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_alu_a_nxt   = r_alu_a;
    w_alu_b_nxt   = r_alu_b;
    w_alu_fun_nxt = r_alu_fun;
    w_result_nxt  = r_result;
    w_tx_data_nxt = r_tx_data;
    w_tx_vld_nxt  = r_tx_vld;
    w_send        = 1'b0;
    w_tx_byte     = '0;
    w_send_done   = IDLE;
`ifdef ALU_CTRL_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
`endif

    case (r_state)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == CMD_LOAD) begin
            w_state_nxt = GET_A;
          end else if (bus.RX_P_DATA == CMD_REUSE) begin
            w_state_nxt = GET_FUN;
          end
        end
      end

      // Operand bytes are plain data here, even if they look like opcodes.
      GET_A: begin
        if (bus.RX_D_VLD) begin
          w_alu_a_nxt = bus.RX_P_DATA;
          w_state_nxt = GET_B;
        end
      end

      GET_B: begin
        if (bus.RX_D_VLD) begin
          w_alu_b_nxt = bus.RX_P_DATA;
          w_state_nxt = GET_FUN;
        end
      end

      GET_FUN: begin
        if (bus.RX_D_VLD) begin
          w_alu_fun_nxt = bus.RX_P_DATA[3:0];
          w_state_nxt   = ALU_RUN;
        end
      end

      ALU_RUN: begin
`ifdef ALU_CTRL_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
        w_state_nxt = ALU_WAIT;
      end

      ALU_WAIT: begin
`ifdef ALU_CTRL_TIMEOUT_EN
        w_cnt_nxt = r_cnt + 1'b1;
        // Valid is tested first so it wins over a timeout in the same cycle.
        if (bus.ALU_OUT_Valid) begin
          w_state_nxt = CAPTURE;
        end else if (w_cnt_nxt == CNT_W'(TIMEOUT)) begin
          w_state_nxt = SEND_ERR;
        end
`else
        if (bus.ALU_OUT_Valid) begin
          w_state_nxt = CAPTURE;
        end
`endif
      end

      // The ALU registers its output, so the data trails Valid by one cycle.
      CAPTURE: begin
        w_result_nxt = bus.ALU_OUT;
        w_state_nxt  = SEND_LO;
      end

      SEND_LO: begin
        w_send      = 1'b1;
        w_tx_byte   = r_result[7:0];
        w_send_done = SEND_HI;
      end

      SEND_HI: begin
        w_send      = 1'b1;
        w_tx_byte   = r_result[15:8];
        w_send_done = IDLE;
      end

`ifdef ALU_CTRL_TIMEOUT_EN
      SEND_ERR: begin
        w_send      = 1'b1;
        w_tx_byte   = ERR_CODE;
        w_send_done = IDLE;
      end
`endif

      default: w_state_nxt = IDLE;
    endcase

    // Present a byte only into an idle transmitter; hold it until BUSY confirms acceptance.
    if (w_send) begin
      if (r_tx_vld) begin
        if (bus.TX_BUSY) begin
          w_tx_vld_nxt = 1'b0;
          w_state_nxt  = w_send_done;
        end
      end else if (!bus.TX_BUSY) begin
        w_tx_vld_nxt  = 1'b1;
        w_tx_data_nxt = w_tx_byte;
      end
    end
  end

  assign bus.ALU_A     = r_alu_a;
  assign bus.ALU_B     = r_alu_b;
  assign bus.ALU_FUN   = r_alu_fun;
  assign bus.ALU_EN    = (r_state == ALU_RUN);
  assign bus.TX_P_DATA = r_tx_data;
  assign bus.TX_D_VLD  = r_tx_vld;
  assign bus.CTRL_BUSY = (r_state != IDLE);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scenario bench for alu_cmd_ctrl: expected TX bytes are queued when the ALU result is
// driven and popped as the controller presents them. Honours ALU_CTRL_TIMEOUT_EN.
module tb_alu_cmd_ctrl;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  alu_cmd_ctrl_if bus ();

  alu_cmd_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] m_a;
  logic [7:0] m_b;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic rx_byte(input logic [7:0] b);
    @(negedge CLK);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(negedge CLK);
    bus.RX_D_VLD  = 1'b0;
  endtask

  // Called on the negedge right after the FUN strobe edge.
  task automatic expect_run(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                            input string tag);
    n_vec++;
    if (bus.ALU_EN !== 1'b1) begin
      n_err++;
      $display("FAIL %s_en_latency: ALU_EN=%b, expected 1", tag, bus.ALU_EN);
    end
    n_vec++;
    if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUN} !== {a, b, f}) begin
      n_err++;
      $display("FAIL %s_operands: A=%h B=%h FUN=%h, expected A=%h B=%h FUN=%h",
               tag, bus.ALU_A, bus.ALU_B, bus.ALU_FUN, a, b, f);
    end
    @(negedge CLK);
    n_vec++;
    if (bus.ALU_EN !== 1'b0) begin
      n_err++;
      $display("FAIL %s_en_pulse: ALU_EN=%b one cycle later, expected 0", tag, bus.ALU_EN);
    end
  endtask

  // Valid in wait cycle 'delay', real data only in the following cycle.
  task automatic alu_respond(input int delay, input logic [15:0] res);
    repeat (delay) @(negedge CLK);
    exp_tx.push_back(res[7:0]);
    exp_tx.push_back(res[15:8]);
    bus.ALU_OUT_Valid = 1'b1;
    bus.ALU_OUT       = ~res;
    @(negedge CLK);
    bus.ALU_OUT_Valid = 1'b0;
    bus.ALU_OUT       = res;
    @(negedge CLK);
    bus.ALU_OUT       = res ^ 16'h5A5A;
  endtask

  // Transmitter model: waits for a byte, optionally delays acceptance, then stays busy.
  task automatic tx_recv(input int pre_accept, input int busy_len, input bit last,
                         input string tag);
    int         t;
    logic [7:0] seen;
    logic [7:0] exp_b;
    t = 0;
    while (bus.TX_D_VLD !== 1'b1 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    n_vec++;
    if (bus.TX_D_VLD !== 1'b1) begin
      n_err++;
      $display("FAIL %s_present: TX_D_VLD=%b after %0d cycles, expected 1", tag, bus.TX_D_VLD, t);
      return;
    end
    n_vec++;
    if (exp_tx.size() == 0) begin
      n_err++;
      $display("FAIL %s_unexpected: got byte %h, expected none", tag, bus.TX_P_DATA);
    end else begin
      exp_b = exp_tx.pop_front();
      if (bus.TX_P_DATA !== exp_b) begin
        n_err++;
        $display("FAIL %s_data: TX_P_DATA=%h, expected %h", tag, bus.TX_P_DATA, exp_b);
      end
    end
    seen = bus.TX_P_DATA;
    repeat (pre_accept) begin
      @(negedge CLK);
      n_vec++;
      if (bus.TX_D_VLD !== 1'b1 || bus.TX_P_DATA !== seen) begin
        n_err++;
        $display("FAIL %s_hold: VLD=%b DATA=%h, expected VLD=1 DATA=%h",
                 tag, bus.TX_D_VLD, bus.TX_P_DATA, seen);
      end
    end
    bus.TX_BUSY = 1'b1;
    @(negedge CLK);
    n_vec++;
    if (bus.TX_D_VLD !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drop: TX_D_VLD=%b after accept, expected 0", tag, bus.TX_D_VLD);
    end
    n_vec++;
    if (bus.CTRL_BUSY !== !last) begin
      n_err++;
      $display("FAIL %s_busy: CTRL_BUSY=%b, expected %b", tag, bus.CTRL_BUSY, !last);
    end
    repeat (busy_len) begin
      @(negedge CLK);
      n_vec++;
      if (bus.TX_D_VLD !== 1'b0) begin
        n_err++;
        $display("FAIL %s_wait_busy: TX_D_VLD=%b while TX_BUSY=1, expected 0", tag, bus.TX_D_VLD);
      end
    end
    bus.TX_BUSY = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    n_vec++;
    if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUN, bus.ALU_EN, bus.TX_P_DATA, bus.TX_D_VLD,
         bus.CTRL_BUSY} !== '0) begin
      n_err++;
      $display("FAIL %s: A=%h B=%h FUN=%h EN=%b TXD=%h TXV=%b BUSY=%b, expected all 0",
               tag, bus.ALU_A, bus.ALU_B, bus.ALU_FUN, bus.ALU_EN, bus.TX_P_DATA,
               bus.TX_D_VLD, bus.CTRL_BUSY);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset_held");
    RST = 1'b0;
    @(negedge CLK);
    check_outputs_zero("reset_released");
    m_a = 8'h00;
    m_b = 8'h00;
  endtask

  task automatic test_add;
    rx_byte(8'hCC);
    n_vec++;
    if (bus.CTRL_BUSY !== 1'b1) begin
      n_err++;
      $display("FAIL add_busy_get_a: CTRL_BUSY=%b, expected 1", bus.CTRL_BUSY);
    end
    rx_byte(8'h05);
    rx_byte(8'h03);
    rx_byte(8'h00);
    m_a = 8'h05;
    m_b = 8'h03;
    expect_run(m_a, m_b, 4'h0, "add");
    alu_respond(2, 16'h0008);
    tx_recv(2, 3, 1'b0, "add_lo");
    tx_recv(0, 1, 1'b1, "add_hi");
  endtask

  task automatic test_reuse;
    rx_byte(8'hDD);
    rx_byte(8'h02);
    expect_run(m_a, m_b, 4'h2, "reuse");
    rx_byte(8'hCC);
    alu_respond(0, 16'h000F);
    n_vec++;
    if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUN} !== {m_a, m_b, 4'h2}) begin
      n_err++;
      $display("FAIL reuse_hold: A=%h B=%h FUN=%h, expected A=%h B=%h FUN=2",
               bus.ALU_A, bus.ALU_B, bus.ALU_FUN, m_a, m_b);
    end
    tx_recv(0, 2, 1'b0, "reuse_lo");
    tx_recv(0, 0, 1'b1, "reuse_hi");
  endtask

  task automatic test_unknown_opcode;
    rx_byte(8'h55);
    n_vec++;
    if (bus.CTRL_BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL unknown_idle: CTRL_BUSY=%b, expected 0", bus.CTRL_BUSY);
    end
    rx_byte(8'hCC);
    rx_byte(8'hFF);
    rx_byte(8'h01);
    rx_byte(8'h00);
    m_a = 8'hFF;
    m_b = 8'h01;
    expect_run(m_a, m_b, 4'h0, "unknown_next");
    alu_respond(3, 16'h0100);
    tx_recv(0, 2, 1'b0, "unknown_lo");
    tx_recv(0, 2, 1'b1, "unknown_hi");
  endtask

  // Opcode-valued operands are data; FUN upper nibble is discarded.
  task automatic test_no_resync;
    rx_byte(8'hCC);
    rx_byte(8'hDD);
    rx_byte(8'hCC);
    rx_byte(8'hA3);
    m_a = 8'hDD;
    m_b = 8'hCC;
    expect_run(m_a, m_b, 4'h3, "no_resync");
    alu_respond(1, 16'hBEEF);
    tx_recv(1, 1, 1'b0, "no_resync_lo");
    tx_recv(1, 1, 1'b1, "no_resync_hi");
  endtask

  // Valid in the last wait cycle (the 15th) still beats the timeout.
  task automatic test_valid_boundary;
    rx_byte(8'hDD);
    rx_byte(8'h07);
    expect_run(m_a, m_b, 4'h7, "boundary");
    alu_respond(14, 16'h1357);
    tx_recv(0, 1, 1'b0, "boundary_lo");
    tx_recv(0, 1, 1'b1, "boundary_hi");
  endtask

  task automatic test_timeout;
    int t;
    rx_byte(8'hDD);
    rx_byte(8'h04);
    expect_run(m_a, m_b, 4'h4, "timeout");
`ifdef ALU_CTRL_TIMEOUT_EN
    exp_tx.push_back(8'hEE);
    t = 0;
    while (bus.TX_D_VLD !== 1'b1 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    n_vec++;
    if (t != 16) begin
      n_err++;
      $display("FAIL timeout_latency: error byte after %0d cycles, expected 16", t);
    end
    tx_recv(0, 2, 1'b1, "timeout_err");
`else
    t = 0;
    repeat (100) begin
      @(negedge CLK);
      n_vec++;
      if (bus.CTRL_BUSY !== 1'b1 || bus.TX_D_VLD !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_wait_forever: cycle %0d BUSY=%b TXV=%b, expected BUSY=1 TXV=0",
                 t, bus.CTRL_BUSY, bus.TX_D_VLD);
      end
      t++;
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_outputs_zero("timeout_reset_exit");
    m_a = 8'h00;
    m_b = 8'h00;
`endif
  endtask

  task automatic test_reset_mid_frame;
    rx_byte(8'hCC);
    rx_byte(8'h07);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_outputs_zero("reset_mid_frame");
    m_a = 8'h00;
    m_b = 8'h00;
    rx_byte(8'hDD);
    rx_byte(8'h00);
    expect_run(m_a, m_b, 4'h0, "after_reset");
    alu_respond(1, 16'h1234);
    tx_recv(0, 1, 1'b0, "after_reset_lo");
    tx_recv(0, 1, 1'b1, "after_reset_hi");
  endtask

  task automatic test_reset_pending_tx;
    int t;
    rx_byte(8'hCC);
    rx_byte(8'h11);
    rx_byte(8'h22);
    rx_byte(8'h01);
    expect_run(8'h11, 8'h22, 4'h1, "pending");
    alu_respond(1, 16'h00AB);
    t = 0;
    while (bus.TX_D_VLD !== 1'b1 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    n_vec++;
    if (bus.TX_D_VLD !== 1'b1) begin
      n_err++;
      $display("FAIL pending_present: TX_D_VLD=%b, expected 1", bus.TX_D_VLD);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_outputs_zero("pending_discard");
    exp_tx.delete();
    m_a = 8'h00;
    m_b = 8'h00;
  endtask

  task automatic test_back_pressure;
    rx_byte(8'hCC);
    rx_byte(8'h40);
    rx_byte(8'h02);
    rx_byte(8'h0B);
    m_a = 8'h40;
    m_b = 8'h02;
    expect_run(m_a, m_b, 4'hB, "bp");
    bus.TX_BUSY = 1'b1;
    alu_respond(0, 16'h8042);
    repeat (20) begin
      @(negedge CLK);
      n_vec++;
      if (bus.TX_D_VLD !== 1'b0) begin
        n_err++;
        $display("FAIL bp_blocked: TX_D_VLD=%b while TX_BUSY=1, expected 0", bus.TX_D_VLD);
      end
    end
    bus.TX_BUSY = 1'b0;
    tx_recv(4, 6, 1'b0, "bp_lo");
    tx_recv(3, 1, 1'b1, "bp_hi");
  endtask

  initial begin
    RST               = 1'b1;
    bus.RX_P_DATA     = 8'h00;
    bus.RX_D_VLD      = 1'b0;
    bus.ALU_OUT       = 16'h0000;
    bus.ALU_OUT_Valid = 1'b0;
    bus.TX_BUSY       = 1'b0;

    test_reset();
    test_add();
    test_reuse();
    test_unknown_opcode();
    test_no_resync();
    test_valid_boundary();
    test_timeout();
    test_reset_mid_frame();
    test_reset_pending_tx();
    test_back_pressure();

    n_vec++;
    if (exp_tx.size() != 0) begin
      n_err++;
      $display("FAIL leftover_bytes: %0d bytes never sent, expected 0", exp_tx.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
